instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction decoder. It holds the program counter and issues single-outstanding requests to instruction memory using a req/gnt/rvalid protocol. Returned words are buffered with their PCs in a small FIFO and presented to decode over a valid/ready handshake. Branch redirects from execute flush the FIFO, discard any in-flight response, and restart fetch at the new PC.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; power of 2, at least 2
PC_STEP, 4, PC increment per granted fetch

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, equal to the PC register
imem_gnt  in  1  memory accepts the request this cycle (sampled only while imem_req=1)
imem_rvalid  in  1  response valid; at most one per grant, 1 or more cycles after gnt
imem_rdata  in  32  response instruction word
redirect_valid  in  1  branch taken / PC redirect, single-cycle pulse
redirect_pc  in  ADDR_W  redirect target
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode accepts the instruction
dec_instr  out  32  instruction at the FIFO head
dec_pc  out  ADDR_W  PC of dec_instr

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC; state=IDLE; FIFO count=0; pending_pc=0; imem_req=0; dec_valid=0. dec_instr and dec_pc are forced to 0 whenever dec_valid=0.
- FSM states: IDLE, REQ, WAIT, DISCARD. imem_req=1 only in REQ.
- IDLE: go to REQ when count<FIFO_DEPTH.
- REQ: on imem_gnt, set pending_pc<=pc and pc<=pc+PC_STEP (wraps modulo 2^ADDR_W), then go to WAIT. Without gnt, stay in REQ.
- WAIT: on imem_rvalid, push {pending_pc, imem_rdata}. Next state is REQ if count_next<FIFO_DEPTH, else IDLE. count_next includes this cycle's push and pop. Back-to-back throughput is one instruction per 2 cycles with 1-cycle memory latency.
- A fetch is started only when the FIFO has a free slot, so a push never overflows. imem_rvalid outside WAIT/DISCARD is ignored.
- Decode side: dec_valid=(count!=0). Pop on dec_valid && dec_ready. A push and a pop in the same cycle leave count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1) takes priority over everything else in that cycle:
  - FIFO is flushed (count=0 next cycle); any same-cycle pop is a no-op.
  - pc<=redirect_pc.
  - IDLE or REQ without gnt: next state REQ; imem_addr=redirect_pc next cycle. Changing the address while gnt=0 is legal.
  - REQ with gnt the same cycle: the granted fetch is stale; pc is not incremented; next state DISCARD.
  - WAIT without rvalid: next state DISCARD.
  - WAIT with rvalid the same cycle: response dropped, not pushed; next state REQ.
  - DISCARD: pc updated; stay in DISCARD.
- DISCARD: on imem_rvalid, drop the data and go to REQ. No push occurs in DISCARD.
- Latency: after reset release, imem_req rises at the first clock edge. With gnt in cycle N and rvalid in cycle N+1, dec_valid=1 in cycle N+2.
- Reset mid-operation aborts any in-flight fetch. Responses arriving after reset in IDLE are ignored.

Test Plan:
- Reset release, RESET_PC=0, gnt=1 always, rvalid 1 cycle after gnt, dec_ready=1 -> imem_addr sequence 0,4,8,…; dec_pc 0,4,8 paired with the matching rdata; dec_valid first high 2 cycles after the first gnt.
- dec_ready=0, FIFO_DEPTH=2 -> exactly 2 grants, then imem_req stays 0 in IDLE. Raise dec_ready -> entries pop in order (pc 0, then 4), fetch resumes at addr 8.
- Redirect to 0x100 while in WAIT, rvalid arriving 3 cycles later with 0xDEADBEEF -> word not delivered, FIFO empty; next imem_addr=0x100; first delivered dec_pc=0x100.
- Redirect to 0x200 in the same cycle as gnt at addr 0x10 -> DISCARD; stale response dropped; next request at 0x200, not 0x204.
- Redirect to 0x40 with the FIFO holding 2 entries and dec_ready=1 -> dec_valid=0 next cycle; the next delivered dec_pc=0x40.
- pc=0xFFFFFFFC granted -> next imem_addr=0x00000000 (wrap). Assert rst=0 mid-WAIT -> imem_req=0 and dec_valid=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that feeds the instruction decoder. It holds the program
// counter and has at most one instruction-memory request outstanding at a
// time. Returned words are stored with their PCs in a small FIFO, and the
// FIFO head is presented to decode. A branch redirect from execute does three
// things: it flushes the FIFO, throws away any response still in flight, and
// restarts fetch at the redirect target.
//
// Handshakes:
//   imem : imem_req is held while the FSM is in REQ. A cycle with
//          imem_req && imem_gnt transfers the address. Exactly one
//          imem_rvalid follows, one or more cycles later.
//   dec  : a transfer happens on every cycle with dec_valid && dec_ready.
//          dec_valid never depends combinationally on dec_ready.
//          dec_instr and dec_pc read as zero while dec_valid is low.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   imem_req       : fetch request valid
//   imem_addr      : fetch address (the PC register)
//   imem_gnt       : memory accepts the request this cycle
//   imem_rvalid    : response valid
//   imem_rdata     : response instruction word
//   redirect_valid : single-cycle PC redirect from execute
//   redirect_pc    : redirect target
//   dec_valid      : instruction available to decode
//   dec_ready      : decode accepts the instruction
//   dec_instr      : instruction at the FIFO head
//   dec_pc         : PC of dec_instr
//   dbg_state      : current FSM state (IDLE=0, REQ=1, WAIT=2, DISCARD=3)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2,
  parameter int unsigned        PC_STEP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [1:0]        dbg_state
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pending_pc;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [31:0]       r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pending_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_push;
  logic              w_pop;

  // A redirect cancels both the push and the pop of its cycle. The FIFO is
  // being flushed anyway, so neither one may change the count.
  always_comb begin
    w_pop  = (r_count != '0) && dec_ready && !redirect_valid;
    w_push = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending_pc;
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
      case (r_state)
        S_IDLE:  w_state_nxt = S_REQ;
        // A grant in this same cycle launches a fetch from the old path.
        // Its response must be swallowed, so the FSM goes to DISCARD.
        S_REQ:   w_state_nxt = imem_gnt ? S_DISCARD : S_REQ;
        // If the response arrives in this cycle, it is dropped and the bus
        // is free again. If not, the FSM waits in DISCARD to absorb it.
        S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_DISCARD;
        default: w_state_nxt = S_DISCARD;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < DEPTH_C) w_state_nxt = S_REQ;
        end
        S_REQ: begin
          if (imem_gnt) begin
            w_pending_nxt = r_pc;
            w_pc_nxt      = r_pc + STEP_C;
            w_state_nxt   = S_WAIT;
          end
        end
        S_WAIT: begin
          // A new fetch starts only when a slot is free after this cycle's
          // push and pop. This guarantees the FIFO can never overflow.
          if (imem_rvalid) w_state_nxt = (w_count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
        end
        S_DISCARD: begin
          if (imem_rvalid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pending_pc <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
      r_count      <= w_count_nxt;
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // The storage needs no reset: an entry is only visible through a nonzero
  // count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_pending_pc;
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign dec_valid = (r_count != '0);
  assign dec_instr = dec_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign dec_pc    = dec_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A behavioural instruction memory grants
// requests and answers after a programmable latency. Every delivered
// {pc, instr} is predicted in exp_q when the memory answers, then compared
// when decode accepts it. Redirects and resets remove predictions that the
// fetch unit must drop.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr;
  logic [AW-1:0] dec_pc;
  logic [1:0]    dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(AW), .RESET_PC('0), .FIFO_DEPTH(2), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [63:0]   exp_q[$];          // {pc, instr}
  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] exp_addr;
  bit            m_busy, m_stale, m_force;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [31:0]   force_word;
  int            lat = 1, gnt_pct = 100, rdy_pct = 100;
  int            grant_cnt, pop_cnt;
  logic [AW-1:0] first_pc, last_pc;

  typedef struct {
    logic [AW-1:0] target;
    int            lat;
    int            gnt_pct;
    int            rdy_pct;
    int            n;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock cycle. Outputs are sampled 1ns after the edge, inputs are
  // driven, and the model and scoreboard advance. Then wait for the next edge.
  task automatic step();
    logic        rv;
    logic [63:0] head;
    check("dec_valid_vs_model", {63'h0, dec_valid}, {63'h0, exp_q.size() != 0});
    if (!dec_valid) check("empty_outputs_zero", {dec_pc, dec_instr}, 64'h0);
    dec_ready = ($urandom_range(0, 99) < rdy_pct);
    rv = m_busy && (m_cnt == 0);
    if (m_busy && !rv) m_cnt--;
    imem_rvalid = rv;
    imem_rdata  = rv ? (m_force ? force_word : word_of(m_addr)) : 32'h0;
    imem_gnt    = imem_req && ($urandom_range(0, 99) < gnt_pct);
    if (redirect_valid && m_busy) m_stale = 1'b1;
    if (dec_valid && dec_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_unexpected: got pc 0x%0h, expected no instruction", dec_pc);
      end else begin
        head = exp_q.pop_front();
        check("dec_pc", {32'h0, dec_pc}, {32'h0, head[63:32]});
        check("dec_instr", {32'h0, dec_instr}, {32'h0, head[31:0]});
        if (pop_cnt == 0) first_pc = dec_pc;
        last_pc = dec_pc;
        pop_cnt++;
      end
    end
    if (redirect_valid) exp_q.delete();
    if (rv) begin
      if (!m_stale) exp_q.push_back({m_addr, imem_rdata});
      m_busy  = 1'b0;
      m_force = 1'b0;
    end
    if (imem_gnt) begin
      check("imem_addr_at_gnt", {32'h0, imem_addr}, {32'h0, exp_addr});
      grant_cnt++;
      m_busy  = 1'b1;
      m_cnt   = lat - 1;
      m_addr  = exp_addr;
      m_stale = redirect_valid;
    end
    if (redirect_valid) exp_addr = redirect_pc;
    else if (imem_gnt) exp_addr = exp_addr + 32'd4;
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_busy = 0; m_stale = 0; m_force = 0; m_cnt = 0;
    exp_addr = '0; grant_cnt = 0; pop_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    check("reset_req", {63'h0, imem_req}, 64'h0);
    check("reset_dec_valid", {63'h0, dec_valid}, 64'h0);
    check("reset_addr", {32'h0, imem_addr}, 64'h0);
    check("reset_dec_pc", {32'h0, dec_pc}, 64'h0);
    rst = 1'b1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    pop_cnt = 0;
  endtask

  task automatic run_pops(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pop_cnt < n && k < budget) begin step(); k++; end
    if (pop_cnt < n) begin
      tests++; fails++;
      $display("FAIL %s: timeout, got %0d deliveries, expected %0d", name, pop_cnt, n);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    int k;
    k = 0;
    while (!imem_req && k < budget) begin step(); k++; end
    if (!imem_req) begin
      tests++; fails++;
      $display("FAIL %s: timeout, got imem_req=0, expected 1", name);
    end
  endtask

  task automatic wait_req_at(input logic [AW-1:0] a, input int budget, input string name);
    int k;
    k = 0;
    while (!(imem_req && imem_addr == a) && k < budget) begin step(); k++; end
    if (!(imem_req && imem_addr == a)) begin
      tests++; fails++;
      $display("FAIL %s: timeout, got addr 0x%0h, expected request at 0x%0h", name, imem_addr, a);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 1, 100, 100, 4, 32'h0000_1000, 32'h0000_100C};
    vecs[1] = '{32'h0000_2000, 2,  70,  60, 5, 32'h0000_2000, 32'h0000_2010};
    vecs[2] = '{32'h0000_3000, 3,  50, 100, 3, 32'h0000_3000, 32'h0000_3008};
    vecs[3] = '{32'h0000_4004, 1, 100,  30, 6, 32'h0000_4004, 32'h0000_4018};
    vecs[4] = '{32'hFFFF_FFF8, 2,  80,  80, 4, 32'hFFFF_FFF8, 32'h0000_0004};

    // Streaming from reset: latency and in-order delivery.
    lat = 1; gnt_pct = 100; rdy_pct = 100;
    do_reset();
    check("req_before_first_edge", {63'h0, imem_req}, 64'h0);
    step();
    check("req_after_first_edge", {63'h0, imem_req}, 64'h1);
    check("first_addr", {32'h0, imem_addr}, 64'h0);
    step();
    check("dec_valid_n_plus_1", {63'h0, dec_valid}, 64'h0);
    step();
    check("dec_valid_n_plus_2", {63'h0, dec_valid}, 64'h1);
    check("first_dec_pc", {32'h0, dec_pc}, 64'h0);
    check("first_dec_instr", {32'h0, dec_instr}, {32'h0, word_of(32'h0)});
    run_pops(6, 40, "stream");
    check("stream_last_pc", {32'h0, last_pc}, 64'd20);

    // Back-pressure: two grants fill the FIFO, then fetch idles.
    do_reset();
    rdy_pct = 0;
    repeat (12) step();
    check("stall_grants", grant_cnt, 64'd2);
    check("stall_req_low", {63'h0, imem_req}, 64'h0);
    check("stall_dec_valid", {63'h0, dec_valid}, 64'h1);
    rdy_pct = 100;
    pop_cnt = 0;
    run_pops(3, 40, "stall_release");
    check("stall_first_pc", {32'h0, first_pc}, 64'h0);
    check("stall_last_pc", {32'h0, last_pc}, 64'h8);

    // Redirect while waiting on a slow response.
    do_reset();
    lat = 4;
    step();
    step();
    m_force = 1'b1; force_word = 32'hDEADBEEF;
    do_redirect(32'h100);
    check("redir_wait_dec_valid", {63'h0, dec_valid}, 64'h0);
    wait_req(20, "redir_wait_req");
    check("redir_wait_addr", {32'h0, imem_addr}, 64'h100);
    run_pops(1, 30, "redir_wait_deliver");
    check("redir_wait_first_pc", {32'h0, first_pc}, 64'h100);

    // Redirect in the same cycle as a grant.
    do_reset();
    lat = 1;
    wait_req_at(32'h10, 40, "gnt_redir_reach");
    do_redirect(32'h200);
    wait_req(20, "gnt_redir_req");
    check("gnt_redir_addr", {32'h0, imem_addr}, 64'h200);
    run_pops(2, 30, "gnt_redir_deliver");
    check("gnt_redir_first_pc", {32'h0, first_pc}, 64'h200);
    check("gnt_redir_last_pc", {32'h0, last_pc}, 64'h204);

    // Redirect with a full FIFO and decode ready.
    do_reset();
    rdy_pct = 0;
    repeat (10) step();
    check("full_dec_valid", {63'h0, dec_valid}, 64'h1);
    rdy_pct = 100;
    do_redirect(32'h40);
    check("full_flush_dec_valid", {63'h0, dec_valid}, 64'h0);
    run_pops(1, 30, "full_redir_deliver");
    check("full_redir_first_pc", {32'h0, first_pc}, 64'h40);

    // PC wraps around the top of the address space.
    do_reset();
    step();
    do_redirect(32'hFFFF_FFFC);
    wait_req_at(32'hFFFF_FFFC, 20, "wrap_reach");
    step();
    wait_req(20, "wrap_req");
    check("wrap_addr", {32'h0, imem_addr}, 64'h0);
    run_pops(2, 30, "wrap_deliver");
    check("wrap_first_pc", {32'h0, first_pc}, 64'hFFFF_FFFC);
    check("wrap_last_pc", {32'h0, last_pc}, 64'h0);

    // Asynchronous reset in the middle of a fetch; late responses ignored.
    do_reset();
    rdy_pct = 0; lat = 3;
    begin
      int k;
      k = 0;
      while (grant_cnt < 2 && k < 40) begin step(); k++; end
    end
    check("midwait_grants", grant_cnt, 64'd2);
    check("midwait_dec_valid", {63'h0, dec_valid}, 64'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", {63'h0, imem_req}, 64'h0);
    check("async_rst_dec_valid", {63'h0, dec_valid}, 64'h0);
    check("async_rst_addr", {32'h0, imem_addr}, 64'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    rst = 1'b1;
    imem_rdata = 32'hCAFE0002;
    @(posedge clk); #1;
    imem_rvalid = 1'b0; imem_rdata = '0;
    clear_model();
    check("post_rst_dec_valid", {63'h0, dec_valid}, 64'h0);
    check("post_rst_req", {63'h0, imem_req}, 64'h1);
    check("post_rst_addr", {32'h0, imem_addr}, 64'h0);
    rdy_pct = 100; lat = 1;
    run_pops(2, 30, "post_rst_deliver");
    check("post_rst_first_pc", {32'h0, first_pc}, 64'h0);

    // Table-driven redirect streams with randomised grant and ready.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat; gnt_pct = vecs[i].gnt_pct; rdy_pct = vecs[i].rdy_pct;
      do_redirect(vecs[i].target);
      run_pops(vecs[i].n, 400, "vec_deliver");
      check("vec_first_pc", {32'h0, first_pc}, {32'h0, vecs[i].exp_first});
      check("vec_last_pc", {32'h0, last_pc}, {32'h0, vecs[i].exp_last});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
